// File: rtl/aer_receiver.sv
// aer_receiver: receive endpoint of the four-wire AER event link (sync, settle, decode, handshake).
// Define AER_RX_COUNT_EN to build the saturating per-event counters; otherwise Cnt_* read 0.
module aer_receiver #(
  parameter int SETTLE_CYC = 2,
  parameter int FE_CYC     = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Ch1,
  input  logic             Ch2,
  input  logic             Up,
  input  logic             Down,
  input  logic             go,
  output logic             Fs_sen,
  output logic             Fe_d,
  output logic             Ch1Up_Out,
  output logic             Ch1Down_Out,
  output logic             Ch2Up_Out,
  output logic             Ch2Down_Out,
  output logic             Err,
  output logic [CNT_W-1:0] Cnt_Ch1Up,
  output logic [CNT_W-1:0] Cnt_Ch1Down,
  output logic [CNT_W-1:0] Cnt_Ch2Up,
  output logic [CNT_W-1:0] Cnt_Ch2Down
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACK    = 2'd2,
    END    = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);
  localparam logic [3:0] FE_LAST     = 4'(FE_CYC - 1);

  // One-hot event {ch1up, ch1down, ch2up, ch2down}; all-zero marks an illegal codeword.
  function automatic logic [3:0] decode(input logic [3:0] code);
    logic [3:0] ev;
    case (code)
      4'b1010: ev = 4'b1000;
      4'b1001: ev = 4'b0100;
      4'b0110: ev = 4'b0010;
      4'b0101: ev = 4'b0001;
      default: ev = 4'b0000;
    endcase
    return ev;
  endfunction

  logic [4:0] sync1, sync2;
  logic       go_s;
  logic [3:0] code_s;
  state_t     state, state_nxt;
  logic [3:0] code_q, code_q_nxt;
  logic [3:0] settle_cnt, settle_cnt_nxt;
  logic [3:0] fe_cnt, fe_cnt_nxt;
  logic       fs_nxt, fe_nxt, err_nxt;
  logic [3:0] ev, ev_nxt;

  assign go_s   = sync2[4];
  assign code_s = sync2[3:0];

  assign Ch1Up_Out   = ev[3];
  assign Ch1Down_Out = ev[2];
  assign Ch2Up_Out   = ev[1];
  assign Ch2Down_Out = ev[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1      <= 5'd0;
      sync2      <= 5'd0;
      state      <= IDLE;
      code_q     <= 4'd0;
      settle_cnt <= 4'd0;
      fe_cnt     <= 4'd0;
      Fs_sen     <= 1'b0;
      Fe_d       <= 1'b0;
      Err        <= 1'b0;
      ev         <= 4'd0;
    end else begin
      sync1      <= {go, Ch1, Ch2, Up, Down};
      sync2      <= sync1;
      state      <= state_nxt;
      code_q     <= code_q_nxt;
      settle_cnt <= settle_cnt_nxt;
      fe_cnt     <= fe_cnt_nxt;
      Fs_sen     <= fs_nxt;
      Fe_d       <= fe_nxt;
      Err        <= err_nxt;
      ev         <= ev_nxt;
    end
  end

  // Strobes are decided on the SETTLE->ACK edge only, so at most one fires per frame.
  always_comb begin
    state_nxt      = state;
    code_q_nxt     = code_q;
    settle_cnt_nxt = settle_cnt;
    fe_cnt_nxt     = fe_cnt;
    fs_nxt         = Fs_sen;
    fe_nxt         = Fe_d;
    ev_nxt         = 4'b0000;
    err_nxt        = 1'b0;
    case (state)
      IDLE: begin
        if (go_s) begin
          state_nxt      = SETTLE;
          code_q_nxt     = code_s;
          settle_cnt_nxt = 4'd0;
        end else begin
          state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (!go_s) begin
          state_nxt = IDLE;
        end else if (code_s != code_q) begin
          code_q_nxt     = code_s;
          settle_cnt_nxt = 4'd0;
        end else if (settle_cnt == SETTLE_LAST) begin
          state_nxt = ACK;
          fs_nxt    = 1'b1;
          ev_nxt    = decode(code_q);
          err_nxt   = (decode(code_q) == 4'b0000);
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
      ACK: begin
        if (!go_s) begin
          state_nxt  = END;
          fs_nxt     = 1'b0;
          fe_nxt     = 1'b1;
          fe_cnt_nxt = FE_LAST;
        end else begin
          state_nxt = ACK;
        end
      end
      END: begin
        if (fe_cnt == 4'd0) begin
          state_nxt = IDLE;
          fe_nxt    = 1'b0;
        end else begin
          fe_cnt_nxt = fe_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        fs_nxt    = 1'b0;
        fe_nxt    = 1'b0;
      end
    endcase
  end

`ifdef AER_RX_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  logic [CNT_W-1:0] cnt [4];

  // Counters follow the registered strobes, so they move one cycle after each event.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) cnt[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (ev[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  assign Cnt_Ch1Up   = cnt[3];
  assign Cnt_Ch1Down = cnt[2];
  assign Cnt_Ch2Up   = cnt[1];
  assign Cnt_Ch2Down = cnt[0];
`else
  assign Cnt_Ch1Up   = {CNT_W{1'b0}};
  assign Cnt_Ch1Down = {CNT_W{1'b0}};
  assign Cnt_Ch2Up   = {CNT_W{1'b0}};
  assign Cnt_Ch2Down = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_aer_receiver.sv
// Self-checking bench for aer_receiver: frame-level timeline model with randomized codes and gaps.
module tb_aer_receiver;
  localparam int S = 2;
  localparam int F = 2;
  localparam int W = 8;
  localparam int L = 2048;

  logic clk = 1'b0;
  logic reset, Ch1, Ch2, Up, Down, go;
  logic Fs_sen, Fe_d, Ch1Up_Out, Ch1Down_Out, Ch2Up_Out, Ch2Down_Out, Err;
  logic [W-1:0] Cnt_Ch1Up, Cnt_Ch1Down, Cnt_Ch2Up, Cnt_Ch2Down;

  aer_receiver #(.SETTLE_CYC(S), .FE_CYC(F), .CNT_W(W)) dut (
    .clk(clk), .reset(reset), .Ch1(Ch1), .Ch2(Ch2), .Up(Up), .Down(Down), .go(go),
    .Fs_sen(Fs_sen), .Fe_d(Fe_d), .Ch1Up_Out(Ch1Up_Out), .Ch1Down_Out(Ch1Down_Out),
    .Ch2Up_Out(Ch2Up_Out), .Ch2Down_Out(Ch2Down_Out), .Err(Err),
    .Cnt_Ch1Up(Cnt_Ch1Up), .Cnt_Ch1Down(Cnt_Ch1Down), .Cnt_Ch2Up(Cnt_Ch2Up), .Cnt_Ch2Down(Cnt_Ch2Down)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int model_cnt [4];

  // Expected-output timeline, indexed by edges since the start of a scenario.
  logic       go_v   [L];
  logic [3:0] code_v [L];
  logic [3:0] ev_e   [L];
  logic       err_e  [L];
  logic       fs_e   [L];
  logic       fe_e   [L];

  // Event bits {ch1up, ch1down, ch2up, ch2down} from the link rules: one channel and one direction.
  function automatic logic [3:0] ref_ev(input logic [3:0] c);
    logic ch1, ch2, up, dn;
    ch1 = c[3]; ch2 = c[2]; up = c[1]; dn = c[0];
    if ((ch1 ^ ch2) && (up ^ dn)) return {ch1 & up, ch1 & dn, ch2 & up, ch2 & dn};
    else return 4'b0000;
  endfunction

  function automatic logic [3:0] obs_ev();
    return {Ch1Up_Out, Ch1Down_Out, Ch2Up_Out, Ch2Down_Out};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic g, input logic [3:0] c);
    go = g;
    {Ch1, Ch2, Up, Down} = c;
  endtask

  task automatic count_event(input logic [3:0] e);
    for (int i = 0; i < 4; i++) if (e[i]) model_cnt[i]++;
  endtask

  task automatic check_outputs(input string name, input int t, input logic [3:0] e_ev,
                               input logic e_err, input logic e_fs, input logic e_fe);
    n_tests++;
    if (obs_ev() !== e_ev) begin
      n_fail++;
      $display("FAIL %s edge %0d strobes got %b expected %b", name, t, obs_ev(), e_ev);
    end
    n_tests++;
    if (Err !== e_err) begin
      n_fail++;
      $display("FAIL %s edge %0d Err got %b expected %b", name, t, Err, e_err);
    end
    n_tests++;
    if (Fs_sen !== e_fs) begin
      n_fail++;
      $display("FAIL %s edge %0d Fs_sen got %b expected %b", name, t, Fs_sen, e_fs);
    end
    n_tests++;
    if (Fe_d !== e_fe) begin
      n_fail++;
      $display("FAIL %s edge %0d Fe_d got %b expected %b", name, t, Fe_d, e_fe);
    end
  endtask

  task automatic test_counters(input string name);
    logic [W-1:0] cobs [4];
    int exp_v, maxv;
    cobs[3] = Cnt_Ch1Up; cobs[2] = Cnt_Ch1Down; cobs[1] = Cnt_Ch2Up; cobs[0] = Cnt_Ch2Down;
    maxv = (1 << W) - 1;
    for (int i = 0; i < 4; i++) begin
`ifdef AER_RX_COUNT_EN
      exp_v = (model_cnt[i] > maxv) ? maxv : model_cnt[i];
`else
      exp_v = 0;
`endif
      n_tests++;
      if (int'(cobs[i]) !== exp_v) begin
        n_fail++;
        $display("FAIL %s counter[%0d] got %0d expected %0d", name, i, cobs[i], exp_v);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      step();
      check_outputs("reset", i, 4'b0000, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    test_counters("reset_cnt");
    drive(1'b0, 4'b0000);
    reset = 1'b0;
    repeat (3) step();
    check_outputs("reset_idle", 0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: random codes/gaps; 1: fixed 1010, tight; 2: plus glitches and code changes; 3: directed list.
  task automatic test_frames(input string name, input int nframes, input int mode);
    int avail, prev_low, r, se, a, l, g, last;
    logic [3:0] c, c2;
    logic [3:0] dir_codes [5];
    bit chg;
    dir_codes[0] = 4'b1010; dir_codes[1] = 4'b1001; dir_codes[2] = 4'b0110;
    dir_codes[3] = 4'b0101; dir_codes[4] = 4'b1100;
    for (int t = 0; t < L; t++) begin
      go_v[t] = 1'b0; code_v[t] = 4'($urandom_range(0, 15));
      ev_e[t] = 4'b0000; err_e[t] = 1'b0; fs_e[t] = 1'b0; fe_e[t] = 1'b0;
    end
    avail = 1;
    prev_low = -1;
    for (int f = 0; f < nframes; f++) begin
      r = prev_low + 1 + $urandom_range(0, F + 2);
      if (mode == 2 && $urandom_range(0, 3) == 0) begin
        g = $urandom_range(1, S);
        for (int t = r; t < r + g; t++) go_v[t] = 1'b1;
        prev_low = r + g;
        avail = (avail > r + g + 4) ? avail : r + g + 4;
      end else begin
        if (mode == 1) c = 4'b1010;
        else if (mode == 3) c = dir_codes[f % 5];
        else c = 4'($urandom_range(0, 15));
        se  = (avail > r + 3) ? avail : r + 3;
        chg = (mode == 2) && (se == r + 3) && ($urandom_range(0, 1) == 1);
        c2  = chg ? 4'($urandom_range(0, 15)) : c;
        a   = (c2 != c) ? se + 1 + S : se + S;
        l   = a - 2 + ((mode == 1) ? 0 : $urandom_range(0, 3));
        for (int t = r; t < l; t++) go_v[t] = 1'b1;
        code_v[r] = c;
        for (int t = r + 1; t < a; t++) code_v[t] = c2;
        ev_e[a]  = ref_ev(c2);
        err_e[a] = (ref_ev(c2) == 4'b0000);
        for (int t = a; t < l + 3; t++) fs_e[t] = 1'b1;
        for (int t = l + 3; t < l + 3 + F; t++) fe_e[t] = 1'b1;
        count_event(ref_ev(c2));
        prev_low = l;
        avail = l + 3 + F + 1;
      end
    end
    last = avail + 3;
    if (last >= L) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeline overflow %0d limit %0d", name, last, L);
      last = L - 1;
    end
    drive(go_v[0], code_v[0]);
    for (int t = 1; t <= last; t++) begin
      step();
      check_outputs(name, t, ev_e[t], err_e[t], fs_e[t], fe_e[t]);
      drive(go_v[t], code_v[t]);
    end
    drive(1'b0, code_v[last]);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] legal [4];
    logic [3:0] c;
    int a, x, a2, l;
    legal[0] = 4'b1010; legal[1] = 4'b1001; legal[2] = 4'b0110; legal[3] = 4'b0101;
    c = legal[$urandom_range(0, 3)];
    a = 3 + S;
    x = a + $urandom_range(0, 2);
    drive(1'b1, c);
    for (int t = 1; t <= x; t++) begin
      step();
      check_outputs("rst_mid_pre", t, (t == a) ? ref_ev(c) : 4'b0000, 1'b0, (t >= a), 1'b0);
    end
    reset = 1'b1;
    step();
    check_outputs("rst_mid_hit", x + 1, 4'b0000, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model_cnt[i] = 0;
    a2 = x + 4 + S;
    l  = a2;
    for (int t = x + 2; t <= l + 3 + F + 2; t++) begin
      step();
      check_outputs("rst_mid_post", t, (t == a2) ? ref_ev(c) : 4'b0000, 1'b0,
                    (t >= a2) && (t < l + 3), (t >= l + 3) && (t < l + 3 + F));
      if (t == l) go = 1'b0;
    end
    count_event(ref_ev(c));
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 4'b0000);
    test_reset();
    test_frames("directed_seq", 10, 3);
    test_counters("directed_cnt");
    test_frames("random", 30, 0);
    test_frames("b2b_glitch_chg", 40, 2);
    test_counters("random_cnt");
    test_reset_mid_frame();
    test_counters("rst_mid_cnt");
    for (int k = 0; k < 6; k++) test_frames("saturate", 50, 1);
    test_counters("saturate_cnt");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
